// File: rtl/io_sp_sreg_wr.sv
// rtl/io_sp_sreg_wr.sv - Stack pointer / SREG write-side owner with CALL/RET stack sequencer
// Multi-byte return-address moves are walked by a small FSM; single push/pop are one-cycle.
module io_sp_sreg_wr #(
  parameter int pc22b = 0,
  parameter int SP_WIDTH = 12,
  parameter logic [SP_WIDTH-1:0] SP_RST = SP_WIDTH'(12'h8FF)
) (
  input  logic        cp2,
  input  logic        rst,
  input  logic [5:0]  adr,
  input  logic        iowe,
  input  logic [7:0]  dbusout,
  input  logic        sp_push,
  input  logic        sp_pop,
  input  logic        sp_call,
  input  logic        sp_ret,
  input  logic [7:0]  sreg_we,
  input  logic [7:0]  sreg_alu_in,
  output logic [15:0] stack_adr,
  output logic        stk_wr,
  output logic        stk_rd,
  output logic [1:0]  stk_byte_sel,
  output logic        busy,
  output logic [7:0]  spl_out,
  output logic [7:0]  sph_out,
  output logic [7:0]  sreg_out,
  output logic        sp_ovf
);

  localparam logic [1:0] LAST_SEL = (pc22b != 0) ? 2'd2 : 2'd1;
  localparam logic [SP_WIDTH-1:0] SP_ONES = '1;

  typedef enum logic [1:0] {IDLE, CALL, RET} state_t;

  state_t              state, state_nxt;
  logic [1:0]          cnt, cnt_nxt;
  logic [SP_WIDTH-1:0] sp, sp_inc, sp_dec, sp_lo_wr, sp_hi_wr;
  logic [15:0]         sp16, sp_inc16;
  logic [7:0]          sreg;
  logic                ovf, dec, inc;
  logic                wr_spl, wr_sph, wr_sreg;

  assign sp_inc  = sp + SP_WIDTH'(1);
  assign sp_dec  = sp - SP_WIDTH'(1);
  assign wr_spl  = iowe && (adr == 6'h3D);
  assign wr_sph  = iowe && (adr == 6'h3E);
  assign wr_sreg = iowe && (adr == 6'h3F);

  // Zero-extended views and byte-merged write values for any SP_WIDTH in 8..16
  always_comb begin
    sp16 = '0;
    sp16[SP_WIDTH-1:0] = sp;
    sp_inc16 = '0;
    sp_inc16[SP_WIDTH-1:0] = sp_inc;
    sp_lo_wr = sp;
    sp_lo_wr[7:0] = dbusout;
    sp_hi_wr = sp;
    for (int i = 8; i < SP_WIDTH; i++) sp_hi_wr[i] = dbusout[i-8];
  end

  always_ff @(posedge cp2 or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    dec          = 1'b0;
    inc          = 1'b0;
    stk_wr       = 1'b0;
    stk_rd       = 1'b0;
    stk_byte_sel = 2'd0;
    case (state)
      IDLE: begin
        if (sp_call) begin
          dec       = 1'b1;
          stk_wr    = 1'b1;
          state_nxt = CALL;
          cnt_nxt   = 2'd1;
        end else if (sp_ret) begin
          inc          = 1'b1;
          stk_rd       = 1'b1;
          stk_byte_sel = LAST_SEL;
          state_nxt    = RET;
          cnt_nxt      = LAST_SEL - 2'd1;
        end else if (sp_push) begin
          dec    = 1'b1;
          stk_wr = 1'b1;
        end else if (sp_pop) begin
          inc    = 1'b1;
          stk_rd = 1'b1;
        end
      end
      CALL: begin
        dec          = 1'b1;
        stk_wr       = 1'b1;
        stk_byte_sel = cnt;
        if (cnt == LAST_SEL) state_nxt = IDLE;
        else cnt_nxt = cnt + 2'd1;
      end
      RET: begin
        inc          = 1'b1;
        stk_rd       = 1'b1;
        stk_byte_sel = cnt;
        if (cnt == 2'd0) state_nxt = IDLE;
        else cnt_nxt = cnt - 2'd1;
      end
      default: state_nxt = IDLE;
    endcase
    stack_adr = dec ? sp16 : (inc ? sp_inc16 : 16'h0000);
  end

  // I/O writes to SPL/SPH take precedence; the stack adjust for that cycle is dropped
  always_ff @(posedge cp2 or posedge rst) begin
    if (rst) begin
      sp  <= SP_RST;
      ovf <= 1'b0;
    end else if (wr_spl) begin
      sp <= sp_lo_wr;
    end else if (wr_sph) begin
      sp  <= sp_hi_wr;
      ovf <= 1'b0;
    end else if (dec) begin
      sp <= sp_dec;
      if (sp == '0) ovf <= 1'b1;
    end else if (inc) begin
      sp <= sp_inc;
      if (sp == SP_ONES) ovf <= 1'b1;
    end
  end

  always_ff @(posedge cp2 or posedge rst) begin
    if (rst) sreg <= 8'h00;
    else if (wr_sreg) sreg <= dbusout;
    else sreg <= (sreg & ~sreg_we) | (sreg_alu_in & sreg_we);
  end

  assign busy     = (state != IDLE);
  assign spl_out  = sp16[7:0];
  assign sph_out  = sp16[15:8];
  assign sreg_out = sreg;
  assign sp_ovf   = ovf;

endmodule

// File: tb/tb_io_sp_sreg_wr.sv
// tb/tb_io_sp_sreg_wr.sv - Randomized bench for io_sp_sreg_wr (2-byte and 3-byte return address)
// Instance 0 uses pc22b=0, instance 1 uses pc22b=1; both share every input.
module tb_io_sp_sreg_wr;

  localparam int M      = 4096;
  localparam int SP_R   = 'h8FF;

  logic       cp2, rst;
  logic [5:0] adr;
  logic       iowe;
  logic [7:0] dbusout;
  logic       sp_push, sp_pop, sp_call, sp_ret;
  logic [7:0] sreg_we, sreg_alu_in;

  logic [15:0] stack_adr [2];
  logic        stk_wr [2];
  logic        stk_rd [2];
  logic [1:0]  stk_byte_sel [2];
  logic        busy [2];
  logic [7:0]  spl_out [2];
  logic [7:0]  sph_out [2];
  logic [7:0]  sreg_out [2];
  logic        sp_ovf [2];

  int tests = 0;
  int fails = 0;

  io_sp_sreg_wr #(.pc22b(0)) dut0 (
    .cp2(cp2), .rst(rst), .adr(adr), .iowe(iowe), .dbusout(dbusout),
    .sp_push(sp_push), .sp_pop(sp_pop), .sp_call(sp_call), .sp_ret(sp_ret),
    .sreg_we(sreg_we), .sreg_alu_in(sreg_alu_in),
    .stack_adr(stack_adr[0]), .stk_wr(stk_wr[0]), .stk_rd(stk_rd[0]),
    .stk_byte_sel(stk_byte_sel[0]), .busy(busy[0]), .spl_out(spl_out[0]),
    .sph_out(sph_out[0]), .sreg_out(sreg_out[0]), .sp_ovf(sp_ovf[0])
  );

  io_sp_sreg_wr #(.pc22b(1)) dut1 (
    .cp2(cp2), .rst(rst), .adr(adr), .iowe(iowe), .dbusout(dbusout),
    .sp_push(sp_push), .sp_pop(sp_pop), .sp_call(sp_call), .sp_ret(sp_ret),
    .sreg_we(sreg_we), .sreg_alu_in(sreg_alu_in),
    .stack_adr(stack_adr[1]), .stk_wr(stk_wr[1]), .stk_rd(stk_rd[1]),
    .stk_byte_sel(stk_byte_sel[1]), .busy(busy[1]), .spl_out(spl_out[1]),
    .sph_out(sph_out[1]), .sreg_out(sreg_out[1]), .sp_ovf(sp_ovf[1])
  );

  initial cp2 = 1'b0;
  always #5 cp2 = ~cp2;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] actual=%0h required=%0h", nm, inst, act, exp);
    end
  endtask

  // Behavioural model: SP as a plain integer, pending return-address beats as a short list
  int m_sp [2];
  int m_ovf [2];
  int m_sreg;
  int nbytes [2] = '{2, 3};
  int bk [2][4];
  int bs [2][4];
  int bn [2];

  always @(negedge cp2) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_sp[i] = SP_R;
        m_ovf[i] = 0;
        bn[i] = 0;
      end
      m_sreg = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        int kind, sel, was_busy, seq;
        was_busy = (bn[i] > 0);
        kind = 0; sel = 0; seq = 0;
        if (bn[i] > 0) begin
          kind = bk[i][0]; sel = bs[i][0]; seq = 1;
          for (int k = 0; k < 3; k++) begin
            bk[i][k] = bk[i][k+1];
            bs[i][k] = bs[i][k+1];
          end
          bn[i]--;
        end else if (sp_call) begin
          kind = 1; sel = 0; seq = 1;
          for (int b = 1; b < nbytes[i]; b++) begin
            bk[i][bn[i]] = 1; bs[i][bn[i]] = b; bn[i]++;
          end
        end else if (sp_ret) begin
          kind = 2; sel = nbytes[i] - 1; seq = 1;
          for (int b = nbytes[i] - 2; b >= 0; b--) begin
            bk[i][bn[i]] = 2; bs[i][bn[i]] = b; bn[i]++;
          end
        end else if (sp_push) kind = 1;
        else if (sp_pop) kind = 2;

        chk("stk_wr", i, stk_wr[i], kind == 1);
        chk("stk_rd", i, stk_rd[i], kind == 2);
        chk("busy", i, busy[i], was_busy != 0);
        chk("spl", i, spl_out[i], m_sp[i] & 255);
        chk("sph", i, sph_out[i], m_sp[i] >> 8);
        chk("sreg", i, sreg_out[i], m_sreg);
        chk("ovf", i, sp_ovf[i], m_ovf[i]);
        if (kind == 1) chk("adr_wr", i, stack_adr[i], m_sp[i]);
        if (kind == 2) chk("adr_rd", i, stack_adr[i], (m_sp[i] + 1) % M);
        if (seq != 0) chk("sel", i, stk_byte_sel[i], sel);

        if (iowe && adr == 6'h3D) m_sp[i] = (m_sp[i] & (M - 256)) | int'(dbusout);
        else if (iowe && adr == 6'h3E) begin
          m_sp[i] = ((int'(dbusout) << 8) | (m_sp[i] & 255)) % M;
          m_ovf[i] = 0;
        end else if (kind == 1) begin
          if (m_sp[i] == 0) m_ovf[i] = 1;
          m_sp[i] = (m_sp[i] + M - 1) % M;
        end else if (kind == 2) begin
          if (m_sp[i] == M - 1) m_ovf[i] = 1;
          m_sp[i] = (m_sp[i] + 1) % M;
        end
      end
      if (iowe && adr == 6'h3F) m_sreg = int'(dbusout);
      else m_sreg = (m_sreg & ~int'(sreg_we)) | (int'(sreg_alu_in) & int'(sreg_we));
    end
  end

  // stb = {call, ret, push, pop}; leaves time at 3 units after the edge
  task automatic drive(input logic [5:0] a, input logic we, input logic [7:0] d,
                       input logic [3:0] stb, input logic [7:0] swe, input logic [7:0] salu);
    @(posedge cp2);
    #1;
    adr = a; iowe = we; dbusout = d;
    {sp_call, sp_ret, sp_push, sp_pop} = stb;
    sreg_we = swe; sreg_alu_in = salu;
    #2;
  endtask

  task automatic idle_c();
    drive(6'h00, 1'b0, 8'h00, 4'b0000, 8'h00, 8'h00);
  endtask

  initial begin
    rst = 1'b1;
    adr = 0; iowe = 0; dbusout = 0;
    sp_push = 0; sp_pop = 0; sp_call = 0; sp_ret = 0;
    sreg_we = 0; sreg_alu_in = 0;
    repeat (2) @(posedge cp2);
    #3;
    chk("rst_sph", 0, sph_out[0], 8'h08);
    chk("rst_spl", 0, spl_out[0], 8'hFF);
    chk("rst_sreg", 0, sreg_out[0], 8'h00);
    chk("rst_busy", 1, busy[1], 1'b0);
    @(posedge cp2);
    #1 rst = 1'b0;

    drive(6'h3D, 1'b1, 8'h3C, 4'b0000, 8'h00, 8'h00);
    idle_c();
    chk("spl_wr", 0, spl_out[0], 8'h3C);
    drive(6'h3D, 1'b1, 8'hFF, 4'b0000, 8'h00, 8'h00);

    drive(6'h00, 1'b0, 8'h00, 4'b0010, 8'h00, 8'h00);
    chk("push_adr", 0, stack_adr[0], 16'h08FF);
    chk("push_wr", 0, stk_wr[0], 1'b1);
    idle_c();
    chk("push_spl", 0, spl_out[0], 8'hFE);
    drive(6'h00, 1'b0, 8'h00, 4'b0001, 8'h00, 8'h00);
    chk("pop_adr", 0, stack_adr[0], 16'h08FF);
    chk("pop_rd", 0, stk_rd[0], 1'b1);
    idle_c();
    chk("pop_spl", 0, spl_out[0], 8'hFF);

    drive(6'h00, 1'b0, 8'h00, 4'b1000, 8'h00, 8'h00);
    chk("call_a_adr", 0, stack_adr[0], 16'h08FF);
    chk("call_a_sel", 1, stk_byte_sel[1], 2'd0);
    idle_c();
    chk("call_b_adr", 0, stack_adr[0], 16'h08FE);
    chk("call_b_sel", 0, stk_byte_sel[0], 2'd1);
    chk("call_b_busy", 0, busy[0], 1'b1);
    idle_c();
    chk("call_c_busy", 0, busy[0], 1'b0);
    chk("call_c_spl", 0, spl_out[0], 8'hFD);
    chk("call_c_adr", 1, stack_adr[1], 16'h08FD);
    chk("call_c_sel", 1, stk_byte_sel[1], 2'd2);
    idle_c();
    chk("call_d_spl", 1, spl_out[1], 8'hFC);

    drive(6'h00, 1'b0, 8'h00, 4'b0100, 8'h00, 8'h00);
    chk("ret_a_adr", 0, stack_adr[0], 16'h08FE);
    chk("ret_a_sel", 0, stk_byte_sel[0], 2'd1);
    chk("ret_a_adr", 1, stack_adr[1], 16'h08FD);
    chk("ret_a_sel", 1, stk_byte_sel[1], 2'd2);
    idle_c();
    chk("ret_b_adr", 0, stack_adr[0], 16'h08FF);
    chk("ret_b_sel", 0, stk_byte_sel[0], 2'd0);
    idle_c();
    chk("ret_c_spl", 0, spl_out[0], 8'hFF);
    chk("ret_c_adr", 1, stack_adr[1], 16'h08FF);
    idle_c();
    chk("ret_d_spl", 1, spl_out[1], 8'hFF);

    drive(6'h00, 1'b0, 8'h00, 4'b0000, 8'h03, 8'hFF);
    idle_c();
    chk("sreg_alu", 0, sreg_out[0], 8'h03);
    drive(6'h3F, 1'b1, 8'h80, 4'b0000, 8'h03, 8'hFF);
    idle_c();
    chk("sreg_io", 0, sreg_out[0], 8'h80);

    drive(6'h3D, 1'b1, 8'h00, 4'b0000, 8'h00, 8'h00);
    drive(6'h3E, 1'b1, 8'h00, 4'b0000, 8'h00, 8'h00);
    drive(6'h00, 1'b0, 8'h00, 4'b0010, 8'h00, 8'h00);
    chk("wrap_adr", 0, stack_adr[0], 16'h0000);
    idle_c();
    chk("wrap_sph", 0, sph_out[0], 8'h0F);
    chk("wrap_spl", 0, spl_out[0], 8'hFF);
    chk("wrap_ovf", 0, sp_ovf[0], 1'b1);
    drive(6'h00, 1'b0, 8'h00, 4'b0010, 8'h00, 8'h00);
    idle_c();
    chk("wrap2_ovf", 0, sp_ovf[0], 1'b1);
    drive(6'h3E, 1'b1, 8'h08, 4'b0000, 8'h00, 8'h00);
    idle_c();
    chk("sph_clr_ovf", 0, sp_ovf[0], 1'b0);

    drive(6'h00, 1'b0, 8'h00, 4'b1000, 8'h00, 8'h00);
    idle_c();
    rst = 1'b1;
    #1;
    chk("rstmid_busy", 0, busy[0], 1'b0);
    chk("rstmid_busy", 1, busy[1], 1'b0);
    chk("rstmid_spl", 0, spl_out[0], 8'hFF);
    chk("rstmid_sph", 1, sph_out[1], 8'h08);
    @(posedge cp2);
    #1 rst = 1'b0;

    drive(6'h00, 1'b0, 8'h00, 4'b1000, 8'h00, 8'h00);
    drive(6'h00, 1'b0, 8'h00, 4'b0010, 8'h00, 8'h00);
    idle_c();
    chk("busy_push_spl", 0, spl_out[0], 8'hFD);
    idle_c();
    chk("busy_push_spl", 1, spl_out[1], 8'hFC);

    for (int c = 0; c < 3000; c++) begin
      int r, ar;
      logic [3:0] stb;
      logic [5:0] a;
      logic [7:0] d;
      r = $urandom_range(0, 99);
      if (r < 10) stb = 4'b1000;
      else if (r < 20) stb = 4'b0100;
      else if (r < 35) stb = 4'b0010;
      else if (r < 50) stb = 4'b0001;
      else if (r < 58) stb = 4'($urandom_range(0, 15));
      else stb = 4'b0000;
      ar = $urandom_range(0, 3);
      a = (ar == 0) ? 6'h3D : (ar == 1) ? 6'h3E : (ar == 2) ? 6'h3F : 6'($urandom_range(0, 63));
      d = 8'($urandom);
      if (ar < 2 && $urandom_range(0, 1) == 0) d = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      drive(a, $urandom_range(0, 7) == 0, d, stb, 8'($urandom), 8'($urandom));
    end

    idle_c();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/io_sp_sreg_wr.md
Name: io_sp_sreg_wr

Overview:
Write-side owner of the core's Stack Pointer (SPL/SPH) and Status Register (SREG). It accepts I/O writes from the data bus, plus stack adjustments from the instruction decoder: single push/pop, and multi-byte CALL/RET sequenced by an internal FSM. It accepts per-bit SREG flag updates from the ALU. It drives spl_out/sph_out/sreg_out to the I/O read multiplexer and supplies the stack address and byte select to the data-memory interface.

Parameters:
pc22b, 0, 1 = 22-bit PC: CALL/RET move 3 bytes; 0 = 2 bytes
SP_WIDTH, 12, implemented SP bits (8..16); upper SPH bits read 0
SP_RST, 12'h8FF, SP reset value (RAMEND)

Ports:
cp2  in  1  core clock, rising edge
rst  in  1  asynchronous active-high reset
adr  in  6  I/O address
iowe  in  1  I/O write strobe
dbusout  in  8  I/O write data
sp_push  in  1  1-cycle strobe: single-byte push
sp_pop  in  1  1-cycle strobe: single-byte pop
sp_call  in  1  1-cycle strobe: start return-address push
sp_ret  in  1  1-cycle strobe: start return-address pop
sreg_we  in  8  per-bit ALU flag write enables
sreg_alu_in  in  8  ALU flag values
stack_adr  out  16  data-memory address for current stack access (zero-extended)
stk_wr  out  1  stack write cycle valid
stk_rd  out  1  stack read cycle valid
stk_byte_sel  out  2  return-address byte index (0=PCL, 1=PCH, 2=PC[21:16])
busy  out  1  CALL/RET sequence in progress
spl_out  out  8  SP[7:0]
sph_out  out  8  SP[15:8], unimplemented bits 0
sreg_out  out  8  SREG
sp_ovf  out  1  sticky SP wrap flag

Behaviour:
- Reset (async, immediate): SP=SP_RST, SREG=8'h00, sp_ovf=0, FSM=IDLE, stk_wr=stk_rd=busy=0, stk_byte_sel=0.
- I/O writes, registered on the next edge:
  - iowe & adr=6'h3D: SP[7:0]<=dbusout.
  - iowe & adr=6'h3E: SP[SP_WIDTH-1:8]<=dbusout bits; sp_ovf<=0.
  - iowe & adr=6'h3F: SREG<=dbusout.
- SREG: each cycle bit i<=sreg_alu_in[i] where sreg_we[i]. A same-cycle I/O write to 6'h3F overrides the ALU update for all bits.
- Outputs: spl_out/sph_out/sreg_out are direct register outputs, so an I/O write is visible the cycle after.
- Single stack ops, accepted only in IDLE:
  - push: stack_adr=SP and stk_wr=1 combinationally in the strobe cycle; SP<=SP-1 (post-decrement).
  - pop: stack_adr=SP+1 and stk_rd=1 in the strobe cycle; SP<=SP+1 (pre-increment).
  - push & pop together: push taken, pop dropped.
- FSM states IDLE, CALL, RET; N = pc22b ? 3 : 2.
  - IDLE→CALL on sp_call (priority over sp_ret, push, pop). Strobe cycle plus N-1 following cycles: stack_adr=SP, stk_wr=1, stk_byte_sel=0,1[,2], SP<=SP-1 each cycle. Return to IDLE after byte N-1.
  - IDLE→RET on sp_ret. N cycles: SP<=SP+1, stack_adr=SP+1, stk_rd=1, stk_byte_sel=N-1 down to 0. Return to IDLE after byte 0.
  - busy=1 from the cycle after the strobe until the last byte cycle inclusive.
  - All stack strobes while busy are ignored.
- Precedence: an I/O write to 6'h3D/6'h3E in the same cycle as any SP adjust wins. The adjust for that cycle is lost; the FSM still advances.
- Arithmetic: modulo 2^SP_WIDTH.
  - Decrement from 0 gives all-ones and sets sp_ovf.
  - Increment from all-ones gives 0 and sets sp_ovf.
  - sp_ovf is cleared only by reset or an SPH write.
- rst mid-sequence: FSM returns to IDLE immediately and SP returns to SP_RST; no partial-stack recovery.

Test Plan:
- Reset: sph_out=8'h08, spl_out=8'hFF, sreg_out=0, busy=0. Write 8'h3C to 6'h3D → next cycle spl_out=8'h3C.
- push at SP=0x8FF: stack_adr=0x08FF, stk_wr=1 in the strobe cycle, then SP=0x8FE. pop: stack_adr=0x08FF, stk_rd=1, SP=0x8FF.
- pc22b=0, SP=0x8FF, sp_call: stk_wr with stack_adr 0x8FF/sel0, then 0x8FE/sel1, busy for 1 cycle, SP=0x8FD. sp_ret returns 0x8FE/sel1, then 0x8FF/sel0, SP=0x8FF. With pc22b=1: 3 cycles each, SP delta 3.
- SREG: sreg_we=8'h03, sreg_alu_in=8'hFF → sreg_out=8'h03. The same with a simultaneous I/O write 8'h80 to 6'h3F → sreg_out=8'h80.
- Wrap: SP=0, push → SP=0xFFF, sp_ovf=1. Push again: sp_ovf stays 1. SPH write 8'h08 → sp_ovf=0.
- Assert rst during the second CALL cycle → busy=0 and SP=0x8FF immediately. A sp_push during busy → SP unchanged by it.
